// File: rtl/branch_predictor_if.sv
// Bundle of the fetch-side lookup and execute-side resolution signals
// exchanged between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      if_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_vld;
  logic [31:0]      ex_pc;
  logic             ex_is_br;
  logic             ex_is_jmp;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic             mispred;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] ctrl_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output if_pc, ex_vld, ex_pc, ex_is_br, ex_is_jmp, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispred, redirect_pc, ctrl_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, ex_vld, ex_pc, ex_is_br, ex_is_jmp, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispred, redirect_pc, ctrl_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a 2-bit saturating PHT,
// indexed bimodally (MODE 1) or gshare-style (MODE 2). MODE 0 never predicts
// taken but still detects mispredictions. Lookup and mispredict detection
// are combinational; training happens at the EX resolution edge.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int MODE    = 1,
  parameter int GHR_W   = 6,
  parameter int CNT_W   = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];
  logic             btb_jmp    [ENTRIES];
  logic [1:0]       pht        [ENTRIES];
  logic [GHR_W-1:0] ghr;
  logic [CNT_W-1:0] ctrl_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] if_pht_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] ex_pht_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_ctrl;
  logic             mispred;
  logic [31:0]      redirect_pc;
  logic             train;
  logic             unused_pc_bits;

  assign if_idx     = bus.if_pc[IDX_W+1:2];
  assign if_tag     = bus.if_pc[31:IDX_W+2];
  assign if_pht_idx = (MODE == 2) ? (if_idx ^ IDX_W'(ghr)) : if_idx;
  assign ex_idx     = bus.ex_pc[IDX_W+1:2];
  assign ex_tag     = bus.ex_pc[31:IDX_W+2];
  assign ex_pht_idx = (MODE == 2) ? (ex_idx ^ IDX_W'(ghr)) : ex_idx;
  assign ex_ctrl    = bus.ex_is_br | bus.ex_is_jmp;
  assign train      = bus.ex_vld & ex_ctrl & (MODE != 0);

  // Byte-offset bits of the PCs never participate in index or tag.
  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

  // Fetch-side lookup against the current (pre-update) table contents.
  always_comb begin
    if_hit          = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    bus.pred_taken  = (MODE != 0) && if_hit && (btb_jmp[if_idx] || pht[if_pht_idx][1]);
    bus.pred_target = bus.pred_taken ? btb_target[if_idx] : (bus.if_pc + 32'd4);
  end

  // Compare the IF prediction with the actual outcome resolved in EX.
  always_comb begin
    mispred     = 1'b0;
    redirect_pc = bus.ex_pc + 32'd4;
    if (bus.ex_vld) begin
      if (ex_ctrl) begin
        mispred = (bus.ex_pred_taken != bus.ex_taken) ||
                  (bus.ex_taken && (bus.ex_pred_target != bus.ex_target));
        if (bus.ex_taken) begin
          redirect_pc = bus.ex_target;
        end
      end else if (bus.ex_pred_taken) begin
        mispred = 1'b1;
      end
    end
  end

  assign bus.mispred     = mispred;
  assign bus.redirect_pc = redirect_pc;
  assign bus.ctrl_cnt    = ctrl_cnt;
  assign bus.mispred_cnt = mispred_cnt;

  // Train BTB/PHT/GHR from resolved control flow and drop stale aliasing entries.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_jmp[i]    <= 1'b0;
        pht[i]        <= 2'b01;
      end
      ghr <= '0;
    end else if (train) begin
      if (bus.ex_is_br) begin
        if (bus.ex_taken && (pht[ex_pht_idx] != 2'b11)) begin
          pht[ex_pht_idx] <= pht[ex_pht_idx] + 2'd1;
        end else if (!bus.ex_taken && (pht[ex_pht_idx] != 2'b00)) begin
          pht[ex_pht_idx] <= pht[ex_pht_idx] - 2'd1;
        end
        ghr <= GHR_W'({ghr, bus.ex_taken});
      end
      if (bus.ex_taken) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= bus.ex_target;
        btb_jmp[ex_idx]    <= bus.ex_is_jmp;
      end
    end else if (bus.ex_vld && !ex_ctrl && bus.ex_pred_taken && (MODE != 0)) begin
      btb_valid[ex_idx] <= 1'b0;
    end
  end

  // Saturating performance counters, active in every mode.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_cnt    <= '0;
      mispred_cnt <= '0;
    end else begin
      if (bus.ex_vld && ex_ctrl && (ctrl_cnt != '1)) begin
        ctrl_cnt <= ctrl_cnt + 1'b1;
      end
      if (mispred && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end
    end
  end
endmodule
